gate_test_sequencer: RTL and testbench



---
 rtl/gate_test_sequencer.sv | 136 +++++++++++++
 tb/tb_gate_test_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_test_sequencer
// Brief    : Sweeps all four input vectors onto a 2-input gate, samples its
//            output after a settle window and checks it against a truth table.
// Revision : 1.0 - initial release
// ============================================================================
module gate_test_sequencer #(
    parameter int         SETTLE_CYCLES = 4,        // 1..255
    parameter logic [3:0] EXPECTED      = 4'b0111,  // indexed by {in1,in2}
    parameter int         PASSES        = 1         // 1..63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_fail,
    output logic       fail_seen
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
    localparam logic [5:0] c_pass_last   = 6'(PASSES - 1);
    localparam logic [7:0] c_err_max     = 8'hFF;

    logic [1:0] r_state;
    logic [1:0] r_vec;
    logic [7:0] r_settle;
    logic [5:0] r_pass_cnt;
    logic       r_in1;
    logic       r_in2;
    logic       r_pass;
    logic [7:0] r_err;
    logic [1:0] r_first;
    logic       r_fail_seen;

    logic       w_exp;
    logic       w_mismatch;
    logic [7:0] w_err_next;

    // Case inequality so an X/Z gate output counts as a mismatch in simulation.
    assign w_exp      = EXPECTED[r_vec];
    assign w_mismatch = (dut_out !== w_exp);
    assign w_err_next = (w_mismatch && (r_err != c_err_max)) ? r_err + 8'd1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= 2'd0;
            r_settle    <= 8'd0;
            r_pass_cnt  <= 6'd0;
            r_in1       <= 1'b0;
            r_in2       <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 8'd0;
            r_first     <= 2'd0;
            r_fail_seen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_SETTLE;
                        r_vec       <= 2'd0;
                        r_in1       <= 1'b0;
                        r_in2       <= 1'b0;
                        r_settle    <= 8'd0;
                        r_pass_cnt  <= 6'd0;
                        r_err       <= 8'd0;
                        r_first     <= 2'd0;
                        r_fail_seen <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    r_settle <= r_settle + 8'd1;
                    if (r_settle == c_settle_last) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_seen) begin
                        r_first     <= r_vec;
                        r_fail_seen <= 1'b1;
                    end
                    if (r_vec != 2'd3) begin
                        r_vec          <= r_vec + 2'd1;
                        {r_in1, r_in2} <= r_vec + 2'd1;
                        r_settle       <= 8'd0;
                        r_state        <= S_SETTLE;
                    end else if (r_pass_cnt != c_pass_last) begin
                        r_pass_cnt <= r_pass_cnt + 6'd1;
                        r_vec      <= 2'd0;
                        r_in1      <= 1'b0;
                        r_in2      <= 1'b0;
                        r_settle   <= 8'd0;
                        r_state    <= S_SETTLE;
                    end else begin
                        // Verdict uses the count including this final sample.
                        r_in1   <= 1'b0;
                        r_in2   <= 1'b0;
                        r_pass  <= (w_err_next == 8'd0);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in1        = r_in1;
    assign in2        = r_in2;
    assign busy       = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done       = (r_state == S_DONE);
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign first_fail = r_first;
    assign fail_seen  = r_fail_seen;

endmodule
`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_test_sequencer
// Brief    : Directed self-checking bench with behavioural gate models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_test_sequencer;

    logic       clk;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic       dut_out_a;
    logic       dut_out_b;
    int         mode;
    int         sel;
    int         checks;
    int         failures;

    logic       in1_a, in2_a, busy_a, done_a, pass_a, fail_seen_a;
    logic [7:0] err_a;
    logic [1:0] first_a;
    logic       in1_b, in2_b, busy_b, done_b, pass_b, fail_seen_b;
    logic [7:0] err_b;
    logic [1:0] first_b;

    gate_test_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a),
        .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(first_a), .fail_seen(fail_seen_a)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(4), .EXPECTED(4'b0111), .PASSES(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
        .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(first_b), .fail_seen(fail_seen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 NAND, 1 stuck-at-1, 2 AND, otherwise stuck-at-0.
    always_comb begin
        dut_out_a = 1'b0;
        case (mode)
            0:       dut_out_a = ~(in1_a & in2_a);
            1:       dut_out_a = 1'b1;
            2:       dut_out_a = in1_a & in2_a;
            default: dut_out_a = 1'b0;
        endcase
    end
    assign dut_out_b = 1'b0;

    logic       o_busy, o_done, o_pass, o_fseen;
    logic [7:0] o_err;
    logic [1:0] o_first;
    logic [1:0] o_vec;
    assign o_busy  = (sel == 0) ? busy_a      : busy_b;
    assign o_done  = (sel == 0) ? done_a      : done_b;
    assign o_pass  = (sel == 0) ? pass_a      : pass_b;
    assign o_fseen = (sel == 0) ? fail_seen_a : fail_seen_b;
    assign o_err   = (sel == 0) ? err_a       : err_b;
    assign o_first = (sel == 0) ? first_a     : first_b;
    assign o_vec   = (sel == 0) ? {in1_a, in2_a} : {in1_b, in2_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_busy"},  {31'd0, o_busy},  0);
        check({tag, "_done"},  {31'd0, o_done},  0);
        check({tag, "_pass"},  {31'd0, o_pass},  0);
        check({tag, "_err"},   {24'd0, o_err},   0);
        check({tag, "_first"}, {30'd0, o_first}, 0);
        check({tag, "_fseen"}, {31'd0, o_fseen}, 0);
        check({tag, "_vec"},   {30'd0, o_vec},   0);
    endtask

    // Called #1 after a rising edge with the selected DUT idle; cycle 0 is the start cycle.
    task automatic run(input int repulse, input int rst_cycle, input int check_seq,
                       input int limit, output int done_cycle, output int done_cnt);
        done_cycle = -1;
        done_cnt   = 0;
        for (int c = 0; c < limit; c++) begin
            if (sel == 0) start_a = (c == 0) || ((repulse != 0) && (c == 3 || c == 15));
            else          start_b = (c == 0);
            rst = (c == rst_cycle);
            @(negedge clk);
            if (o_done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (check_seq != 0 && c >= 1 && c <= 20)
                check($sformatf("vec_c%0d", c), {30'd0, o_vec}, (c - 1) / 5);
            if (c == rst_cycle + 1)
                check_idle_reset("after_rst");
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b0;
    endtask

    int dc, dn;

    initial begin
        checks   = 0;
        failures = 0;
        mode     = 0;
        sel      = 0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ideal NAND
        mode = 0;
        run(0, -10, 1, 25, dc, dn);
        check("nand_done_cycle", dc, 21);
        check("nand_done_cnt", dn, 1);
        check("nand_pass", {31'd0, o_pass}, 1);
        check("nand_err", {24'd0, o_err}, 0);
        check("nand_fseen", {31'd0, o_fseen}, 0);

        // Stuck-at-1: only vector 11 disagrees
        mode = 1;
        run(0, -10, 0, 25, dc, dn);
        check("sa1_done_cycle", dc, 21);
        check("sa1_pass", {31'd0, o_pass}, 0);
        check("sa1_err", {24'd0, o_err}, 1);
        check("sa1_first", {30'd0, o_first}, 3);
        check("sa1_fseen", {31'd0, o_fseen}, 1);

        // AND instead of NAND: every vector disagrees
        mode = 2;
        run(0, -10, 0, 25, dc, dn);
        check("and_err", {24'd0, o_err}, 4);
        check("and_first", {30'd0, o_first}, 0);
        check("and_pass", {31'd0, o_pass}, 0);

        // PASSES=3, stuck-at-0: three mismatches per sweep
        sel = 1;
        run(0, -10, 0, 65, dc, dn);
        check("p3_done_cycle", dc, 61);
        check("p3_done_cnt", dn, 1);
        check("p3_err", {24'd0, o_err}, 9);
        check("p3_first", {30'd0, o_first}, 0);
        check("p3_pass", {31'd0, o_pass}, 0);
        sel = 0;

        // start re-pulsed mid-run is ignored
        mode = 0;
        run(1, -10, 1, 25, dc, dn);
        check("repulse_done_cycle", dc, 21);
        check("repulse_done_cnt", dn, 1);
        check("repulse_pass", {31'd0, o_pass}, 1);
        check("repulse_err", {24'd0, o_err}, 0);

        // Reset mid vector 01 with partial errors already recorded
        mode = 2;
        run(0, 10, 0, 30, dc, dn);
        check("rst_done_cnt", dn, 0);
        mode = 0;
        run(0, -10, 0, 25, dc, dn);
        check("post_rst_done_cycle", dc, 21);
        check("post_rst_pass", {31'd0, o_pass}, 1);
        check("post_rst_err", {24'd0, o_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
